// File: rtl/pkt_crc_sched.sv
// pkt_crc_sched
//   Arbitrates between a token requester and a data requester and serializes
//   the winning packet (PID, then body) one bit per cycle toward a CRC unit.
//   After the body it waits for the CRC unit to finish sending, pulses done
//   and returns to IDLE, where the next grant can be issued.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   tok_req/pid/data    token request, PID and 11-bit addr+endp body
//   tok_gnt             pulse: token request accepted, operands latched
//   dat_req/pid/len     data request, PID and payload length in bytes
//   dat_data            payload, byte0 in [7:0], each byte LSB first
//   dat_gnt             pulse: data request accepted, operands latched
//   crc_inb             serial bit toward the CRC unit
//   crc_recving         packet body (PID or payload) in progress
//   crc_start           PID phase, excluded from the CRC
//   crc_pkttype         1 = CRC16 (data), 0 = CRC5 (token)
//   pause               downstream stall, holds the serializer
//   crc_sending         CRC unit still emitting packet/CRC
//   busy, done          not-IDLE flag, completion pulse
module pkt_crc_sched #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tok_req,
  input  logic [3:0]             tok_pid,
  input  logic [10:0]            tok_data,
  output logic                   tok_gnt,
  input  logic                   dat_req,
  input  logic [3:0]             dat_pid,
  input  logic [3:0]             dat_len,
  input  logic [8*MAX_BYTES-1:0] dat_data,
  output logic                   dat_gnt,
  output logic                   crc_inb,
  output logic                   crc_recving,
  output logic                   crc_start,
  output logic                   crc_pkttype,
  input  logic                   pause,
  input  logic                   crc_sending,
  output logic                   busy,
  output logic                   done
);

  // Payload shift register must hold either a token body or a full data payload.
  localparam int         PW      = (8 * MAX_BYTES > 11) ? 8 * MAX_BYTES : 11;
  localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_PAYLOAD,
    ST_WAITCRC,
    ST_DONE
  } state_t;

  state_t          state_reg;
  logic [6:0]      cnt_reg;
  logic [7:0]      pid_sr_reg;    // {~pid, pid}, shifted right so bit 0 is on the wire
  logic [PW-1:0]   pay_sr_reg;    // body bits, shifted right so bit 0 is on the wire
  logic [6:0]      last_idx_reg;  // counter value of the final payload bit
  logic            type_reg;      // 1 = data packet
  logic            empty_reg;     // data packet with no payload
  logic            last_dat_reg;  // most recent grant went to the data requester

  logic            pick_tok;
  logic            pick_dat;
  logic [3:0]      len_clamped;
  logic [6:0]      dat_last_idx;

  // Round-robin: on a tie the requester that did not win last time is picked.
  always_comb begin
    pick_tok = tok_req && (!dat_req || last_dat_reg);
    pick_dat = dat_req && !pick_tok;
  end

  always_comb begin
    len_clamped  = (dat_len > MAX_LEN) ? MAX_LEN : dat_len;
    // Wraps for len 0, but such packets skip PAYLOAD via empty_reg.
    dat_last_idx = {len_clamped, 3'b000} - 7'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 7'd0;
      pid_sr_reg   <= 8'd0;
      pay_sr_reg   <= '0;
      last_idx_reg <= 7'd0;
      type_reg     <= 1'b0;
      empty_reg    <= 1'b0;
      last_dat_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= 7'd0;
          if (pick_tok) begin
            state_reg    <= ST_PID;
            pid_sr_reg   <= {~tok_pid, tok_pid};
            pay_sr_reg   <= PW'(tok_data);
            last_idx_reg <= 7'd10;
            type_reg     <= 1'b0;
            empty_reg    <= 1'b0;
            last_dat_reg <= 1'b0;
          end else if (pick_dat) begin
            state_reg    <= ST_PID;
            pid_sr_reg   <= {~dat_pid, dat_pid};
            pay_sr_reg   <= PW'(dat_data);
            last_idx_reg <= dat_last_idx;
            type_reg     <= 1'b1;
            empty_reg    <= (len_clamped == 4'd0);
            last_dat_reg <= 1'b1;
          end
        end

        ST_PID: begin
          if (!pause) begin
            pid_sr_reg <= pid_sr_reg >> 1;
            if (cnt_reg == 7'd7) begin
              cnt_reg   <= 7'd0;
              state_reg <= empty_reg ? ST_WAITCRC : ST_PAYLOAD;
            end else begin
              cnt_reg <= cnt_reg + 7'd1;
            end
          end
        end

        ST_PAYLOAD: begin
          if (!pause) begin
            pay_sr_reg <= pay_sr_reg >> 1;
            if (cnt_reg == last_idx_reg) begin
              cnt_reg   <= 7'd0;
              state_reg <= ST_WAITCRC;
            end else begin
              cnt_reg <= cnt_reg + 7'd1;
            end
          end
        end

        ST_WAITCRC: begin
          if (!crc_sending) begin
            cnt_reg   <= 7'd0;
            state_reg <= ST_DONE;
          end
        end

        ST_DONE: begin
          cnt_reg   <= 7'd0;
          state_reg <= ST_IDLE;
        end

        default: begin
          cnt_reg   <= 7'd0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state; rst forces them low in the reset cycle
  // itself so that a mid-packet reset never shows a stray bit or grant.
  always_comb begin
    tok_gnt     = !rst && (state_reg == ST_IDLE) && pick_tok;
    dat_gnt     = !rst && (state_reg == ST_IDLE) && pick_dat;
    crc_start   = !rst && (state_reg == ST_PID);
    crc_recving = !rst && ((state_reg == ST_PID) || (state_reg == ST_PAYLOAD));
    crc_inb     = 1'b0;
    if (!rst && state_reg == ST_PID)     crc_inb = pid_sr_reg[0];
    if (!rst && state_reg == ST_PAYLOAD) crc_inb = pay_sr_reg[0];
    crc_pkttype = !rst && type_reg &&
                  ((state_reg == ST_PID) || (state_reg == ST_PAYLOAD) ||
                   (state_reg == ST_WAITCRC));
    busy        = !rst && (state_reg != ST_IDLE);
    done        = !rst && (state_reg == ST_DONE);
  end

endmodule

// File: tb/tb_pkt_crc_sched.sv
// tb_pkt_crc_sched
//   Scenario tasks drive requests; each granted packet's expected bit stream
//   (inb, start, pkttype) is pushed to a queue and popped by a monitor every
//   cycle in which a body bit advances.
module tb_pkt_crc_sched;

  logic        clk;
  logic        rst;
  logic        tok_req;
  logic [3:0]  tok_pid;
  logic [10:0] tok_data;
  logic        tok_gnt;
  logic        dat_req;
  logic [3:0]  dat_pid;
  logic [3:0]  dat_len;
  logic [63:0] dat_data;
  logic        dat_gnt;
  logic        crc_inb;
  logic        crc_recving;
  logic        crc_start;
  logic        crc_pkttype;
  logic        pause;
  logic        crc_sending;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [2:0] exp_t;  // {inb, start, pkttype}
  exp_t exp_q[$];

  pkt_crc_sched #(.MAX_BYTES(8)) dut (
    .clk(clk), .rst(rst),
    .tok_req(tok_req), .tok_pid(tok_pid), .tok_data(tok_data), .tok_gnt(tok_gnt),
    .dat_req(dat_req), .dat_pid(dat_pid), .dat_len(dat_len), .dat_data(dat_data),
    .dat_gnt(dat_gnt),
    .crc_inb(crc_inb), .crc_recving(crc_recving), .crc_start(crc_start),
    .crc_pkttype(crc_pkttype),
    .pause(pause), .crc_sending(crc_sending),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the serialized packet.
  function automatic void push_pkt(input bit is_data, input logic [3:0] pid,
                                   input logic [63:0] payload, input logic [3:0] len);
    int         nbits;
    logic [3:0] l;
    logic       b;
    l     = (len > 4'd8) ? 4'd8 : len;
    nbits = is_data ? 8 * int'(l) : 11;
    for (int i = 0; i < 8; i++) begin
      b = (i < 4) ? pid[i] : ~pid[i-4];
      exp_q.push_back({b, 1'b1, is_data});
    end
    for (int i = 0; i < nbits; i++) exp_q.push_back({payload[i], 1'b0, is_data});
  endfunction

  // Scoreboard consumer: one expected entry per advancing body bit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && crc_recving && !pause) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL body_bit: got inb=%b with no bit required", crc_inb);
      end else begin
        e = exp_q.pop_front();
        if ({crc_inb, crc_start, crc_pkttype} !== e) begin
          n_fail++;
          $display("FAIL body_bit: got inb/start/type=%b required %b",
                   {crc_inb, crc_start, crc_pkttype}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int ndone, output bit idle_ok);
    ndone   = 0;
    idle_ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!busy) begin
        idle_ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; tok_req = 1'b1; dat_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done} !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b required 00000000",
                 {tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done});
      end
      tick();
    end
    rst = 1'b0; tok_req = 1'b0; dat_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done} !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got %b required 00000000",
               {tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done});
    end
    exp_q.delete();
    $display("reset sequence complete");
  endtask

  task automatic test_token();
    int body = 0, gnts = 0, k = 0, nd;
    bit found = 0, ok;
    tick();
    tok_req = 1'b1; tok_pid = 4'h1; tok_data = 11'h0A5; crc_sending = 1'b1; pause = 1'b0;
    push_pkt(1'b0, 4'h1, 64'(11'h0A5), 4'd0);
    @(negedge clk);
    n_checks++;
    if ({tok_gnt, dat_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL token_grant: got tok/dat=%b required 10", {tok_gnt, dat_gnt});
    end
    for (int c = 0; c < 60; c++) begin
      tick();
      tok_req = 1'b0; tok_pid = 4'hE; tok_data = 11'h7FF;
      @(negedge clk);
      if (tok_gnt) gnts++;
      if (crc_recving) body++;
      else if (busy) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found || body != 19) begin
      n_fail++;
      $display("FAIL token_body_cycles: got %0d required 19", body);
    end
    n_checks++;
    if (gnts != 0) begin
      n_fail++;
      $display("FAIL token_gnt_pulse: got %0d extra pulses required 0", gnts);
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) crc_sending = 1'b0;
      @(negedge clk);
      if (done) begin
        k = c;
        break;
      end
      n_checks++;
      if ({crc_inb, crc_recving, crc_start, busy} !== 4'b0001) begin
        n_fail++;
        $display("FAIL token_waitcrc_outputs: got %b required 0001",
                 {crc_inb, crc_recving, crc_start, busy});
      end
    end
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL token_done_latency: got %0d required 3", k);
    end
    wait_idle(nd, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL token_idle: got idle=%0d left=%0d required idle=1 left=0", ok, exp_q.size());
    end
    $display("token packet pid=1 body=%0d done_after=%0d", body, k);
  endtask

  task automatic test_tie();
    int  ngrant = 0, dones = 0, nd;
    bit  pred, ok;
    tick();
    rst = 1'b1; tok_req = 1'b1; dat_req = 1'b1; crc_sending = 1'b0;
    tok_pid = 4'h5; tok_data = 11'h3C1; dat_pid = 4'hC; dat_len = 4'd1; dat_data = 64'h96;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 300 && ngrant < 4; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (tok_gnt || dat_gnt) begin
        pred = ngrant[0];
        n_checks++;
        if ({tok_gnt, dat_gnt} !== {~pred, pred}) begin
          n_fail++;
          $display("FAIL tie_order: grant %0d got tok/dat=%b required %b",
                   ngrant, {tok_gnt, dat_gnt}, {~pred, pred});
        end
        n_checks++;
        if (dones != ngrant) begin
          n_fail++;
          $display("FAIL tie_done_between: got %0d dones required %0d", dones, ngrant);
        end
        if (pred) push_pkt(1'b1, 4'hC, 64'h96, 4'd1);
        else      push_pkt(1'b0, 4'h5, 64'(11'h3C1), 4'd0);
        $display("tie grant %0d to %s", ngrant, pred ? "data" : "token");
        ngrant++;
      end
      tick();
    end
    tok_req = 1'b0; dat_req = 1'b0;
    n_checks++;
    if (ngrant != 4) begin
      n_fail++;
      $display("FAIL tie_grant_count: got %0d required 4", ngrant);
    end
    wait_idle(nd, ok);
    dones += nd;
    n_checks++;
    if (!ok || dones != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL tie_finish: got dones=%0d left=%0d required dones=4 left=0", dones, exp_q.size());
    end
  endtask

  task automatic test_data_len();
    int  body, pay, nd;
    bit  ok;
    // len 0: PID only.
    body = 0;
    tick();
    dat_req = 1'b1; dat_pid = 4'h3; dat_len = 4'd0; dat_data = 64'hFFFF_FFFF_FFFF_FFFF;
    crc_sending = 1'b0;
    push_pkt(1'b1, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0);
    @(negedge clk);
    n_checks++;
    if (dat_gnt !== 1'b1 || tok_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_grant: got tok/dat=%b required 01", {tok_gnt, dat_gnt});
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      dat_req = 1'b0;
      @(negedge clk);
      if (crc_recving) body++;
      else break;
    end
    n_checks++;
    if (body != 8 || {busy, crc_pkttype} !== 2'b11) begin
      n_fail++;
      $display("FAIL len0_pid_only: got body=%0d busy/type=%b required body=8 busy/type=11",
               body, {busy, crc_pkttype});
    end
    wait_idle(nd, ok);
    n_checks++;
    if (!ok || nd != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL len0_finish: got done=%0d left=%0d required done=1 left=0", nd, exp_q.size());
    end
    $display("data packet pid=3 len=0 body=%0d", body);
    // len 12: clamped to 8 bytes.
    pay = 0;
    tick();
    dat_req = 1'b1; dat_pid = 4'h4; dat_len = 4'd12; dat_data = 64'h0123_4567_89AB_CDEF;
    push_pkt(1'b1, 4'h4, 64'h0123_4567_89AB_CDEF, 4'd12);
    @(negedge clk);
    for (int c = 0; c < 200; c++) begin
      tick();
      dat_req = 1'b0; dat_len = 4'd1;
      @(negedge clk);
      if (crc_recving && !crc_start) pay++;
      else if (!crc_recving) break;
    end
    n_checks++;
    if (pay != 64) begin
      n_fail++;
      $display("FAIL len12_clamp: got %0d payload bits required 64", pay);
    end
    wait_idle(nd, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL len12_finish: got idle=%0d left=%0d required idle=1 left=0", ok, exp_q.size());
    end
    $display("data packet pid=4 len=12 payload=%0d", pay);
  endtask

  task automatic test_pause();
    int   body = 0, nd;
    bit   found = 0, ok;
    logic prev_inb = 1'b0;
    tick();
    dat_req = 1'b1; dat_pid = 4'hA; dat_len = 4'd2; dat_data = 64'hC3A5;
    crc_sending = 1'b0;
    push_pkt(1'b1, 4'hA, 64'hC3A5, 4'd2);
    @(negedge clk);
    n_checks++;
    if (dat_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_grant: got %b required 1", dat_gnt);
    end
    for (int c = 1; c <= 60; c++) begin
      tick();
      dat_req = 1'b0;
      pause = (c >= 13 && c <= 15);
      @(negedge clk);
      if (c == 14 || c == 15) begin
        n_checks++;
        if (crc_inb !== prev_inb || crc_recving !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_hold: cycle %0d got inb=%b recv=%b required inb=%b recv=1",
                   c, crc_inb, crc_recving, prev_inb);
        end
      end
      prev_inb = crc_inb;
      if (crc_recving) body++;
      else if (busy) begin
        found = 1;
        break;
      end
    end
    pause = 1'b0;
    n_checks++;
    if (!found || body != 27) begin
      n_fail++;
      $display("FAIL pause_body_time: got %0d required 27", body);
    end
    wait_idle(nd, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pause_finish: got idle=%0d left=%0d required idle=1 left=0", ok, exp_q.size());
    end
    $display("data packet pid=A len=2 paused body=%0d", body);
  endtask

  task automatic test_reset_mid();
    int nd;
    bit ok;
    tick();
    dat_req = 1'b1; dat_pid = 4'h6; dat_len = 4'd2; dat_data = 64'h5A3C;
    crc_sending = 1'b0;
    push_pkt(1'b1, 4'h6, 64'h5A3C, 4'd2);
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      tick();
      dat_req = 1'b0;
      @(negedge clk);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done} !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_during: got %b required 00000000",
               {tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done});
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if ({tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done} !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_after: got %b required 00000000",
               {tok_gnt, dat_gnt, crc_inb, crc_recving, crc_start, crc_pkttype, busy, done});
    end
    tick();
    tok_req = 1'b1; tok_pid = 4'h9; tok_data = 11'h155;
    push_pkt(1'b0, 4'h9, 64'(11'h155), 4'd0);
    @(negedge clk);
    n_checks++;
    if ({tok_gnt, dat_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_regrant: got tok/dat=%b required 10", {tok_gnt, dat_gnt});
    end
    tick();
    tok_req = 1'b0;
    wait_idle(nd, ok);
    n_checks++;
    if (!ok || nd != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_done_count: got %0d left=%0d required 1 left=0", nd, exp_q.size());
    end
    $display("reset mid-payload, token pid=9 regranted");
  endtask

  task automatic test_waitcrc_hold();
    int k = 0, nd;
    bit found = 0, ok;
    tick();
    tok_req = 1'b1; tok_pid = 4'h2; tok_data = 11'h7F0; crc_sending = 1'b1;
    push_pkt(1'b0, 4'h2, 64'(11'h7F0), 4'd0);
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      tick();
      tok_req = 1'b0;
      @(negedge clk);
      if (!crc_recving && busy) begin
        found = 1;
        break;
      end
    end
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 10) crc_sending = 1'b0;
      @(negedge clk);
      if (done) begin
        k = c;
        break;
      end
      n_checks++;
      if ({busy, crc_recving} !== 2'b10) begin
        n_fail++;
        $display("FAIL waitcrc_hold: cycle %0d got busy/recv=%b required 10", c, {busy, crc_recving});
      end
    end
    n_checks++;
    if (!found || k != 11) begin
      n_fail++;
      $display("FAIL waitcrc_done_latency: got %0d required 11", k);
    end
    wait_idle(nd, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL waitcrc_finish: got idle=%0d left=%0d required idle=1 left=0", ok, exp_q.size());
    end
    $display("token packet pid=2 held in WAITCRC, done_after=%0d", k);
  endtask

  initial begin
    rst = 1'b1; tok_req = 1'b0; tok_pid = 4'h0; tok_data = 11'h0;
    dat_req = 1'b0; dat_pid = 4'h0; dat_len = 4'd0; dat_data = 64'h0;
    pause = 1'b0; crc_sending = 1'b0;
    test_reset();
    test_token();
    test_tie();
    test_data_len();
    test_pause();
    test_reset_mid();
    test_waitcrc_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
